// File: rtl/pipe_interlock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_interlock_ctrl                                                        |
// | Stall/flush sequencer for the 5-stage pipeline: load-use interlock,        |
// | mul/div/mod handshake with timeout, and taken-branch flush.                |
// | Optional macro PERF_CNT_EN builds the three performance counters.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pipe_interlock_ctrl #(
   parameter int MD_TIMEOUT = 64,
   parameter int BR_PENALTY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_of,
   input  logic [31:0] instr_e,
   input  logic        branch_taken_e,
   input  logic        md_done,
   output logic        stall_pc,
   output logic        stall_of,
   output logic        stall_e,
   output logic        bubble_e,
   output logic        bubble_m,
   output logic        flush_of,
   output logic        md_start,
   output logic        md_err,
   output logic [31:0] ld_stall_cnt,
   output logic [31:0] md_stall_cnt,
   output logic [31:0] flush_cnt
);

   localparam int c_cnt_w_raw = $clog2(MD_TIMEOUT + 1);
   localparam int c_cnt_w     = (c_cnt_w_raw < 2) ? 2 : c_cnt_w_raw;
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_md_last = c_cnt_w'(MD_TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_br_init = c_cnt_w'(BR_PENALTY - 1);

   localparam logic [4:0] c_op_mul  = 5'b00010;
   localparam logic [4:0] c_op_div  = 5'b00011;
   localparam logic [4:0] c_op_mod  = 5'b00100;
   localparam logic [4:0] c_op_not  = 5'b01000;
   localparam logic [4:0] c_op_mov  = 5'b01001;
   localparam logic [4:0] c_op_nop  = 5'b01101;
   localparam logic [4:0] c_op_ld   = 5'b01110;
   localparam logic [4:0] c_op_beq  = 5'b10000;
   localparam logic [4:0] c_op_bgt  = 5'b10001;
   localparam logic [4:0] c_op_b    = 5'b10010;
   localparam logic [4:0] c_op_call = 5'b10011;
   localparam logic [4:0] c_op_ret  = 5'b10100;
   localparam logic [4:0] c_op_rs2_max = 5'b01100;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MD_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic               md_err_q, md_err_d;

   logic [4:0] w_op_of;
   logic [4:0] w_op_e;
   logic [3:0] w_rd_e;
   logic       w_uses_rs1;
   logic       w_uses_rs2;
   logic       w_is_md_e;
   logic       w_load_use;
   logic       w_ld_stall;
   logic       w_unused;

   assign w_op_of    = instr_of[31:27];
   assign w_op_e     = instr_e[31:27];
   assign w_rd_e     = instr_e[25:22];
   assign w_uses_rs1 = !(w_op_of inside {c_op_not, c_op_mov, c_op_nop, c_op_beq,
                                         c_op_bgt, c_op_b, c_op_call, c_op_ret});
   assign w_uses_rs2 = !instr_of[26] && (w_op_of <= c_op_rs2_max);
   assign w_is_md_e  = w_op_e inside {c_op_mul, c_op_div, c_op_mod};
   // st's data register is deliberately absent: RW->MA forwarding covers it
   assign w_load_use = (w_op_e == c_op_ld) &&
                       ((w_uses_rs1 && instr_of[21:18] == w_rd_e) ||
                        (w_uses_rs2 && instr_of[17:14] == w_rd_e) ||
                        (w_op_of == c_op_ret && w_rd_e == 4'd15));
   assign w_unused   = ^{instr_of[13:0], instr_e[26], instr_e[21:0]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      md_err_d   = md_err_q;
      stall_pc   = 1'b0;
      stall_of   = 1'b0;
      stall_e    = 1'b0;
      bubble_e   = 1'b0;
      bubble_m   = 1'b0;
      flush_of   = 1'b0;
      md_start   = 1'b0;
      w_ld_stall = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (branch_taken_e) begin
               flush_of = 1'b1;
               bubble_e = 1'b1;
               cnt_d    = c_br_init;
               if (BR_PENALTY > 1) state_d = ST_FLUSH;
            end else if (w_is_md_e) begin
               md_start = 1'b1;
               stall_pc = 1'b1;
               stall_of = 1'b1;
               stall_e  = 1'b1;
               bubble_m = 1'b1;
               cnt_d    = '0;
               state_d  = ST_MD_WAIT;
            end else if (w_load_use) begin
               stall_pc   = 1'b1;
               stall_of   = 1'b1;
               bubble_e   = 1'b1;
               w_ld_stall = 1'b1;
            end
         end
         ST_MD_WAIT: begin
            cnt_d = cnt_q + c_cnt_one;
            // md_done wins over a coincident timeout
            if (md_done) begin
               state_d = ST_RUN;
            end else if (cnt_q == c_md_last) begin
               md_err_d = 1'b1;
               state_d  = ST_RUN;
            end else begin
               stall_pc = 1'b1;
               stall_of = 1'b1;
               stall_e  = 1'b1;
               bubble_m = 1'b1;
            end
         end
         ST_FLUSH: begin
            flush_of = 1'b1;
            cnt_d    = cnt_q - c_cnt_one;
            if (cnt_q <= c_cnt_one) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      if (rst) begin
         stall_pc   = 1'b0;
         stall_of   = 1'b0;
         stall_e    = 1'b0;
         bubble_e   = 1'b0;
         bubble_m   = 1'b0;
         flush_of   = 1'b0;
         md_start   = 1'b0;
         w_ld_stall = 1'b0;
      end
   end

   assign md_err = md_err_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         cnt_q    <= '0;
         md_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         md_err_q <= md_err_d;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] ld_cnt_q, ld_cnt_d;
   logic [31:0] md_cnt_q, md_cnt_d;
   logic [31:0] fl_cnt_q, fl_cnt_d;

   always_comb begin
      ld_cnt_d = ld_cnt_q + {31'd0, w_ld_stall};
      md_cnt_d = md_cnt_q + {31'd0, stall_e};
      fl_cnt_d = fl_cnt_q + {31'd0, flush_of};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_cnt_q <= '0;
         md_cnt_q <= '0;
         fl_cnt_q <= '0;
      end else begin
         ld_cnt_q <= ld_cnt_d;
         md_cnt_q <= md_cnt_d;
         fl_cnt_q <= fl_cnt_d;
      end
   end

   assign ld_stall_cnt = ld_cnt_q;
   assign md_stall_cnt = md_cnt_q;
   assign flush_cnt    = fl_cnt_q;
`else
   assign ld_stall_cnt = 32'd0;
   assign md_stall_cnt = 32'd0;
   assign flush_cnt    = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_interlock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_interlock_ctrl                                                     |
// | Directed bench with a rule-level reference model for pipe_interlock_ctrl.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pipe_interlock_ctrl;

   localparam int MD_TIMEOUT = 8;
   localparam int BR_PENALTY = 2;
`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_MUL  = 5'b00010;
   localparam logic [4:0] OP_DIV  = 5'b00011;
   localparam logic [4:0] OP_MOD  = 5'b00100;
   localparam logic [4:0] OP_NOT  = 5'b01000;
   localparam logic [4:0] OP_MOV  = 5'b01001;
   localparam logic [4:0] OP_NOP  = 5'b01101;
   localparam logic [4:0] OP_LD   = 5'b01110;
   localparam logic [4:0] OP_ST   = 5'b01111;
   localparam logic [4:0] OP_BEQ  = 5'b10000;
   localparam logic [4:0] OP_BGT  = 5'b10001;
   localparam logic [4:0] OP_B    = 5'b10010;
   localparam logic [4:0] OP_CALL = 5'b10011;
   localparam logic [4:0] OP_RET  = 5'b10100;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_of, instr_e;
   logic        branch_taken_e, md_done;
   logic        stall_pc, stall_of, stall_e, bubble_e, bubble_m, flush_of, md_start, md_err;
   logic [31:0] ld_stall_cnt, md_stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit          m_act, n_act;
   int          m_wait, n_wait;
   int          m_fleft, n_fleft;
   bit          m_err, n_err;
   logic [31:0] m_ld, m_md, m_fl, n_ld, n_md, n_fl;

   pipe_interlock_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .BR_PENALTY(BR_PENALTY)) dut (
      .clk(clk), .rst(rst), .instr_of(instr_of), .instr_e(instr_e),
      .branch_taken_e(branch_taken_e), .md_done(md_done),
      .stall_pc(stall_pc), .stall_of(stall_of), .stall_e(stall_e),
      .bubble_e(bubble_e), .bubble_m(bubble_m), .flush_of(flush_of),
      .md_start(md_start), .md_err(md_err), .ld_stall_cnt(ld_stall_cnt),
      .md_stall_cnt(md_stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [4:0] op, input logic imm,
                                      input logic [3:0] rd, input logic [3:0] rs1,
                                      input logic [3:0] rs2);
      return {op, imm, rd, rs1, rs2, 14'd0};
   endfunction

   function automatic bit reads_reg(input logic [31:0] ins, input logic [3:0] r);
      logic [4:0] op;
      bit r1, r2;
      op = ins[31:27];
      r1 = !(op inside {OP_NOT, OP_MOV, OP_NOP, OP_BEQ, OP_BGT, OP_B, OP_CALL, OP_RET});
      r2 = (ins[26] == 1'b0) && (op <= 5'b01100);
      return (r1 && ins[21:18] == r) || (r2 && ins[17:14] == r) ||
             (op == OP_RET && r == 4'd15);
   endfunction

   function automatic bit load_use(input logic [31:0] of_i, input logic [31:0] e_i);
      return (e_i[31:27] == OP_LD) && reads_reg(of_i, e_i[25:22]);
   endfunction

   function automatic bit is_md(input logic [31:0] e_i);
      return e_i[31:27] inside {OP_MUL, OP_DIV, OP_MOD};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] of_i, input logic [31:0] e_i,
                        input logic br, input logic dn);
      @(posedge clk);
      #1;
      rst = r; instr_of = of_i; instr_e = e_i; branch_taken_e = br; md_done = dn;
      #1;
   endtask

   // per-cycle comparison against the rule-level model
   initial begin : model_cmp
      bit x_pc, x_of, x_e, x_be, x_bm, x_fl, x_ms, lu;
      m_act = 0; m_wait = 0; m_fleft = 0; m_err = 0;
      m_ld = '0; m_md = '0; m_fl = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         {x_pc, x_of, x_e, x_be, x_bm, x_fl, x_ms, lu} = '0;
         n_act = m_act; n_wait = m_wait; n_fleft = m_fleft; n_err = m_err;
         if (rst) begin
            n_act = 0; n_wait = 0; n_fleft = 0; n_err = 0;
         end else if (m_act) begin
            n_wait = m_wait + 1;
            if (md_done) n_act = 0;
            else if (m_wait + 1 == MD_TIMEOUT) begin
               n_act = 0; n_err = 1;
            end else begin
               x_pc = 1; x_of = 1; x_e = 1; x_bm = 1;
            end
         end else if (m_fleft > 0) begin
            x_fl = 1; n_fleft = m_fleft - 1;
         end else if (branch_taken_e) begin
            x_fl = 1; x_be = 1; n_fleft = BR_PENALTY - 1;
         end else if (is_md(instr_e)) begin
            x_ms = 1; x_pc = 1; x_of = 1; x_e = 1; x_bm = 1;
            n_act = 1; n_wait = 0;
         end else if (load_use(instr_of, instr_e)) begin
            lu = 1; x_pc = 1; x_of = 1; x_be = 1;
         end
         chk("model_ctrl",
             {24'd0, stall_pc, stall_of, stall_e, bubble_e, bubble_m, flush_of, md_start, md_err},
             {24'd0, x_pc, x_of, x_e, x_be, x_bm, x_fl, x_ms, (m_err & ~rst)});
         chk("model_ld_stall_cnt", ld_stall_cnt, PERF ? m_ld : 32'd0);
         chk("model_md_stall_cnt", md_stall_cnt, PERF ? m_md : 32'd0);
         chk("model_flush_cnt", flush_cnt, PERF ? m_fl : 32'd0);
         n_ld = rst ? 32'd0 : m_ld + (lu ? 32'd1 : 32'd0);
         n_md = rst ? 32'd0 : m_md + (x_e ? 32'd1 : 32'd0);
         n_fl = rst ? 32'd0 : m_fl + (x_fl ? 32'd1 : 32'd0);
         @(posedge clk);
         m_act = n_act; m_wait = n_wait; m_fleft = n_fleft; m_err = n_err;
         m_ld = n_ld; m_md = n_md; m_fl = n_fl;
      end
   end

   initial begin : stim
      logic [31:0] nop_i, ld3, add_u3, st3, ld7, sub_r7, sub_imm, ld15, ret_i, mov_i;
      logic [31:0] mul_i, div_i, md0, f0, l0;
      int n;
      nop_i   = mk(OP_NOP, 1'b0, 4'd0, 4'd0, 4'd0);
      ld3     = mk(OP_LD, 1'b1, 4'd3, 4'd1, 4'd0);
      add_u3  = mk(OP_ADD, 1'b0, 4'd5, 4'd3, 4'd2);
      st3     = mk(OP_ST, 1'b1, 4'd3, 4'd4, 4'd0);
      ld7     = mk(OP_LD, 1'b1, 4'd7, 4'd1, 4'd0);
      sub_r7  = mk(OP_SUB, 1'b0, 4'd1, 4'd2, 4'd7);
      sub_imm = mk(OP_SUB, 1'b1, 4'd1, 4'd2, 4'd7);
      ld15    = mk(OP_LD, 1'b1, 4'd15, 4'd1, 4'd0);
      ret_i   = mk(OP_RET, 1'b0, 4'd0, 4'd0, 4'd0);
      mov_i   = mk(OP_MOV, 1'b1, 4'd1, 4'd3, 4'd0);
      mul_i   = mk(OP_MUL, 1'b0, 4'd6, 4'd1, 4'd2);
      div_i   = mk(OP_DIV, 1'b0, 4'd6, 4'd1, 4'd2);

      rst = 1'b1; instr_of = nop_i; instr_e = nop_i; branch_taken_e = 1'b0; md_done = 1'b0;
      drive(1, nop_i, nop_i, 0, 0);
      drive(1, nop_i, mul_i, 0, 0);
      chk("md_start_in_reset", {31'd0, md_start}, 32'd0);
      drive(0, nop_i, nop_i, 0, 0);
      chk("idle_stall_pc", {31'd0, stall_pc}, 32'd0);
      chk("idle_md_err", {31'd0, md_err}, 32'd0);

      // load-use via rs1, then store-data register exclusion
      drive(0, add_u3, ld3, 0, 0);
      chk("lu_rs1_ctrl", {29'd0, stall_pc, stall_of, bubble_e}, 32'd7);
      chk("lu_rs1_stall_e", {31'd0, stall_e}, 32'd0);
      drive(0, add_u3, nop_i, 0, 0);
      chk("lu_rs1_release", {31'd0, stall_pc}, 32'd0);
      drive(0, st3, ld3, 0, 0);
      chk("lu_st_data", {31'd0, stall_pc}, 32'd0);

      // rs2 register vs immediate, ret on r15, mov immediate form
      drive(0, sub_r7, ld7, 0, 0);
      chk("lu_rs2", {31'd0, bubble_e}, 32'd1);
      drive(0, sub_r7, nop_i, 0, 0);
      drive(0, sub_imm, ld7, 0, 0);
      chk("lu_rs2_imm", {31'd0, stall_pc}, 32'd0);
      drive(0, ret_i, ld15, 0, 0);
      chk("lu_ret_r15", {31'd0, stall_of}, 32'd1);
      drive(0, mov_i, ld3, 0, 0);
      chk("lu_mov_imm", {31'd0, stall_pc}, 32'd0);

      // mul handshake, md_done five cycles after md_start
      md0 = md_stall_cnt;
      drive(0, nop_i, mul_i, 0, 0);
      chk("md_start_pulse", {29'd0, md_start, stall_e, bubble_m}, 32'd7);
      n = int'(stall_e);
      for (int i = 1; i <= 4; i++) begin
         drive(0, nop_i, mul_i, 0, 0);
         n += int'(stall_e);
         if (i == 1) chk("md_start_once", {31'd0, md_start}, 32'd0);
      end
      drive(0, nop_i, mul_i, 0, 1);
      chk("md_release", {30'd0, stall_e, bubble_m}, 32'd0);
      drive(0, nop_i, nop_i, 0, 0);
      chk("md_stall_cycles", 32'(n), 32'd5);
      chk("md_err_ok", {31'd0, md_err}, 32'd0);
      chk("md_stall_cnt_delta", md_stall_cnt - md0, PERF ? 32'd5 : 32'd0);

      // timeout: md_done never arrives
      drive(0, nop_i, div_i, 0, 0);
      n = int'(stall_e);
      for (int i = 1; i <= MD_TIMEOUT; i++) begin
         drive(0, nop_i, div_i, 0, 0);
         n += int'(stall_e);
      end
      chk("to_err_not_yet", {31'd0, md_err}, 32'd0);
      drive(0, nop_i, nop_i, 0, 0);
      chk("to_stall_cycles", 32'(n), 32'd8);
      chk("to_md_err", {31'd0, md_err}, 32'd1);
      drive(0, nop_i, nop_i, 0, 0);
      drive(0, nop_i, nop_i, 0, 0);
      chk("to_md_err_sticky", {31'd0, md_err}, 32'd1);

      // branch flush with a load-use pattern present
      f0 = flush_cnt; l0 = ld_stall_cnt;
      drive(0, add_u3, ld3, 1, 0);
      chk("br_cycle0", {29'd0, flush_of, bubble_e, stall_pc}, 32'd6);
      drive(0, add_u3, ld3, 0, 0);
      chk("br_cycle1", {30'd0, flush_of, stall_pc}, 32'd2);
      drive(0, nop_i, nop_i, 0, 0);
      chk("br_done", {31'd0, flush_of}, 32'd0);
      chk("flush_cnt_delta", flush_cnt - f0, PERF ? 32'd2 : 32'd0);
      chk("ld_stall_cnt_delta", ld_stall_cnt - l0, 32'd0);

      // reset on the third wait cycle
      drive(0, nop_i, mul_i, 0, 0);
      drive(0, nop_i, mul_i, 0, 0);
      drive(0, nop_i, mul_i, 0, 0);
      drive(1, nop_i, mul_i, 0, 0);
      chk("rst_mid_wait_ctrl",
          {25'd0, stall_pc, stall_of, stall_e, bubble_m, md_start, md_err, flush_of}, 32'd0);
      drive(0, nop_i, nop_i, 0, 0);
      chk("rst_after_stall_e", {31'd0, stall_e}, 32'd0);
      chk("rst_after_md_err", {31'd0, md_err}, 32'd0);
      chk("rst_after_counters", ld_stall_cnt | md_stall_cnt | flush_cnt, 32'd0);

      // md_done coinciding with the timeout cycle counts as success
      drive(0, nop_i, mul_i, 0, 0);
      for (int i = 1; i < MD_TIMEOUT; i++) drive(0, nop_i, mul_i, 0, 0);
      drive(0, nop_i, mul_i, 0, 1);
      chk("to_done_release", {31'd0, stall_e}, 32'd0);
      drive(0, nop_i, nop_i, 0, 0);
      chk("to_done_no_err", {31'd0, md_err}, 32'd0);
      drive(0, nop_i, nop_i, 0, 0);
      drive(0, nop_i, nop_i, 0, 0);

      @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
